param_shift_register: RTL and testbench
=======================================

// Module: param_shift_register
// PURPOSE
//   Parametrised successor to the fixed-width serial shift registers.
//   - Configurable width and shift direction.
//   - Four operating modes: hold, shift, rotate, parallel load.
//   - Parallel readout, plus a bit counter that flags each completed WIDTH-bit frame.
//   - Serves as the serial<->parallel conversion stage between serial links and word-wide datapaths.
// PARAMETERS
//   WIDTH      8  register length in bits; legal range WIDTH >= 2
//   MSB_FIRST  1  1: shift toward MSB, sIn enters bit 0, sOut = bit WIDTH-1
//                 0: shift toward LSB, sIn enters bit WIDTH-1, sOut = bit 0
//   RESET_VAL  0  WIDTH-bit value loaded into the register on reset
// PORTS
//   clk       in   1      clock, all state updates on the rising edge
//   rst       in   1      asynchronous reset, active-low
//   en        in   1      clock enable; 0 = hold all state
//   mode      in   2      00 hold, 01 shift, 10 rotate, 11 parallel load
//   sIn       in   1      serial input, sampled in shift mode only
//   pIn       in   WIDTH  parallel input, sampled in load mode only
//   sOut      out  1      serial output, combinational from register end bit
//   pOut      out  WIDTH  parallel output, equals register contents
//   bitCount  out  CW     shifts/rotates since last frame boundary; CW = $clog2(WIDTH+1)
//   frameDone out  1      registered one-cycle pulse at each frame boundary
// BEHAVIOUR
//   Reset (rst low, independent of clk):
//     - register <= RESET_VAL, bitCount <= 0, frameDone <= 0.
//     - Takes effect immediately, even mid-frame.
//     - Register does not update on any edge while rst is low.
//   Register update on rising edge with en=1:
//     - hold (00): register and bitCount unchanged.
//     - shift (01), MSB_FIRST=1: reg <= {reg[W-2:0], sIn}.
//     - shift (01), MSB_FIRST=0: reg <= {sIn, reg[W-1:1]}.
//     - rotate (10): as shift, but the current sOut is fed back in place of sIn.
//     - load (11): reg <= pIn, bitCount <= 0, and no frameDone is produced.
//   en=0: register and bitCount hold regardless of mode; frameDone <= 0.
//   Bit counter (advances on shift or rotate with en=1):
//     - bitCount < WIDTH-1: bitCount <= bitCount + 1, frameDone <= 0.
//     - bitCount == WIDTH-1: bitCount <= 0 (wrap), frameDone <= 1.
//   Pulse and output timing:
//     - frameDone is high for exactly one cycle, then returns to 0 on the next edge.
//     - Back-to-back frames give one pulse every WIDTH shifts.
//     - bitCount never reaches WIDTH.
//     - sOut and pOut have zero latency from the register: a new sOut is visible right after each edge.
//   Boundary cases:
//     - Load on the same edge a frame would complete: load wins; bitCount 0, frameDone 0.
//     - Reset released mid-cycle: the first counted edge is the first rising edge after rst returns high.
//     - Illegal WIDTH < 2 is caught by an elaboration-time $error.
// TESTING  (WIDTH=8 unless stated)
//   1. rst low with random sIn/pIn
//      -> pOut=8'h00, sOut=0, bitCount=0, frameDone=0 at once, without a clk edge.
//   2. MSB_FIRST=1, mode=01, sIn = 1,0,1,0,0,1,0,1 over 8 edges
//      -> pOut=8'hA5, bitCount=0.
//      -> frameDone high only in the cycle after the 8th edge; 8 more shifts give a 2nd pulse.
//   3. Load 8'h81, then rotate 3 edges
//      -> sOut sequence 1,0,0,0; pOut 8'h03, 8'h06, 8'h0C; bitCount 3.
//   4. Load 8'hF0, shift 8 edges with sIn=0
//      -> sOut 1,1,1,1,0,0,0,0; pOut=8'h00; frameDone pulses once.
//   5. Shift 5, drop rst for 3 ns between edges (bitCount 0 immediately), then shift 8
//      -> frameDone only after the 8th post-reset shift.
//      -> en=0 for 4 edges with mode=01: pOut and bitCount frozen.
//   6. MSB_FIRST=0, shift 1,0,1,0,0,1,0,1 (LSB first)
//      -> pOut=8'hA5, sOut follows bit 0.
//      -> Load at bitCount=7 -> bitCount 0, no frameDone.

Source files
------------

// File: rtl/param_shift_register.sv
// Parametrised serial/parallel shift register with hold, shift, rotate and load modes.
// A bit counter flags each completed WIDTH-bit frame with a registered one-cycle pulse.
module param_shift_register #(
   parameter int               WIDTH     = 8,
   parameter bit               MSB_FIRST = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sIn,
   input  logic [WIDTH-1:0] pIn,
   output logic             sOut,
   output logic [WIDTH-1:0] pOut,
   output logic [CW-1:0]    bitCount,
   output logic             frameDone
);

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_SHIFT  = 2'b01,
      MODE_ROTATE = 2'b10,
      MODE_LOAD   = 2'b11
   } mode_t;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("param_shift_register: WIDTH must be at least 2");
      end
   endgenerate

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    count;
   logic             done;
   logic             feed;
   mode_t            op;

   assign op   = mode_t'(mode);
   // Rotate recirculates the bit currently leaving the register.
   assign feed = (op == MODE_ROTATE) ? sOut : sIn;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign sOut    = shreg[WIDTH-1];
         assign shifted = {shreg[WIDTH-2:0], feed};
      end else begin : g_lsb_first
         assign sOut    = shreg[0];
         assign shifted = {feed, shreg[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= RESET_VAL;
         count <= '0;
         done  <= 1'b0;
      end else if (en) begin
         case (op)
            MODE_SHIFT, MODE_ROTATE: begin
               shreg <= shifted;
               if (count == LAST_BIT) begin
                  count <= '0;
                  done  <= 1'b1;
               end else begin
                  count <= count + 1'b1;
                  done  <= 1'b0;
               end
            end
            // Load restarts framing and suppresses any pulse due on this edge.
            MODE_LOAD: begin
               shreg <= pIn;
               count <= '0;
               done  <= 1'b0;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end else begin
         done <= 1'b0;
      end
   end

   assign pOut      = shreg;
   assign bitCount  = count;
   assign frameDone = done;

endmodule

// File: tb/tb_param_shift_register.sv
// Directed bench for param_shift_register: one MSB-first and one LSB-first instance, WIDTH=8.
module tb_param_shift_register;

   localparam logic [1:0] HOLD = 2'b00, SHIFT = 2'b01, ROTATE = 2'b10, LOAD = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_en, b_en;
   logic [1:0] a_mode, b_mode;
   logic       a_sin, b_sin;
   logic [7:0] a_pin, b_pin;
   logic       a_sout, b_sout;
   logic [7:0] a_pout, b_pout;
   logic [3:0] a_cnt, b_cnt;
   logic       a_done, b_done;

   int n_cmp = 0;
   int n_err = 0;

   param_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1), .RESET_VAL(8'h00)) dut_a (
      .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .sIn(a_sin), .pIn(a_pin),
      .sOut(a_sout), .pOut(a_pout), .bitCount(a_cnt), .frameDone(a_done)
   );

   param_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0), .RESET_VAL(8'h00)) dut_b (
      .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .sIn(b_sin), .pIn(b_pin),
      .sOut(b_sout), .pOut(b_pout), .bitCount(b_cnt), .frameDone(b_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_en = 1'b1; a_mode = LOAD; a_pin = 8'h5A;
      tick();
      a_mode = SHIFT; a_sin = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (a_pout !== 8'h6B || a_cnt !== 4'd2) begin
         n_err++;
         $display("FAIL pre_reset: pOut=%h bitCount=%0d, expected 6b / 2", a_pout, a_cnt);
      end
      // Assert reset between edges with random inputs; outputs must clear at once.
      #2;
      rst = 1'b0; a_mode = LOAD; a_pin = 8'($urandom_range(1, 255)); a_sin = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (a_pout !== 8'h00 || a_sout !== 1'b0 || a_cnt !== 4'd0 || a_done !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: pOut=%h sOut=%b bitCount=%0d frameDone=%b, expected 00/0/0/0",
                  a_pout, a_sout, a_cnt, a_done);
      end
      tick();
      n_cmp++;
      if (a_pout !== 8'h00 || a_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL reset_held_over_edge: pOut=%h bitCount=%0d, expected 00 / 0", a_pout, a_cnt);
      end
      n_cmp++;
      if (b_pout !== 8'h00 || b_sout !== 1'b0 || b_cnt !== 4'd0 || b_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_lsb_dut: pOut=%h sOut=%b bitCount=%0d frameDone=%b, expected 00/0/0/0",
                  b_pout, b_sout, b_cnt, b_done);
      end
      a_mode = HOLD;
      rst = 1'b1;
   endtask

   task automatic test_shift_msb_first();
      logic       bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_p [8] = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h14, 8'h29, 8'h52, 8'hA5};
      a_mode = SHIFT;
      for (int i = 0; i < 8; i++) begin
         a_sin = bits[i];
         tick();
         n_cmp++;
         if (a_pout !== exp_p[i] || a_cnt !== 4'((i + 1) % 8) || a_done !== (i == 7)) begin
            n_err++;
            $display("FAIL shift_msb[%0d]: pOut=%h bitCount=%0d frameDone=%b, expected %h/%0d/%b",
                     i, a_pout, a_cnt, a_done, exp_p[i], (i + 1) % 8, (i == 7));
         end
      end
      // Second back-to-back frame of zeros: pulse drops after one cycle, returns on 8th shift.
      a_sin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++;
         if (a_done !== (i == 7) || a_cnt !== 4'((i + 1) % 8)) begin
            n_err++;
            $display("FAIL second_frame[%0d]: frameDone=%b bitCount=%0d, expected %b/%0d",
                     i, a_done, a_cnt, (i == 7), (i + 1) % 8);
         end
      end
      n_cmp++;
      if (a_pout !== 8'h00) begin
         n_err++;
         $display("FAIL second_frame_data: pOut=%h, expected 00", a_pout);
      end
   endtask

   task automatic test_rotate();
      logic [7:0] exp_p [3] = '{8'h03, 8'h06, 8'h0C};
      a_mode = LOAD; a_pin = 8'h81;
      tick();
      n_cmp++;
      if (a_pout !== 8'h81 || a_sout !== 1'b1 || a_cnt !== 4'd0 || a_done !== 1'b0) begin
         n_err++;
         $display("FAIL load_81: pOut=%h sOut=%b bitCount=%0d frameDone=%b, expected 81/1/0/0",
                  a_pout, a_sout, a_cnt, a_done);
      end
      a_mode = ROTATE; a_sin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (a_pout !== exp_p[i] || a_sout !== 1'b0) begin
            n_err++;
            $display("FAIL rotate[%0d]: pOut=%h sOut=%b, expected %h/0", i, a_pout, a_sout, exp_p[i]);
         end
      end
      n_cmp++;
      if (a_cnt !== 4'd3) begin
         n_err++;
         $display("FAIL rotate_count: bitCount=%0d, expected 3", a_cnt);
      end
   endtask

   task automatic test_load_then_shift();
      logic       exp_s [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [7:0] exp_p [8] = '{8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      a_mode = LOAD; a_pin = 8'hF0;
      tick();
      a_mode = SHIFT; a_sin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (a_sout !== exp_s[i]) begin
            n_err++;
            $display("FAIL shift_out[%0d]: sOut=%b, expected %b", i, a_sout, exp_s[i]);
         end
         tick();
         n_cmp++;
         if (a_pout !== exp_p[i] || a_done !== (i == 7)) begin
            n_err++;
            $display("FAIL shift_f0[%0d]: pOut=%h frameDone=%b, expected %h/%b",
                     i, a_pout, a_done, exp_p[i], (i == 7));
         end
      end
      a_mode = HOLD;
      tick();
      n_cmp++;
      if (a_done !== 1'b0 || a_pout !== 8'h00 || a_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL pulse_width: frameDone=%b pOut=%h bitCount=%0d, expected 0/00/0", a_done, a_pout, a_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      a_mode = SHIFT; a_sin = 1'b1;
      repeat (5) tick();
      n_cmp++;
      if (a_cnt !== 4'd5 || a_pout !== 8'h1F) begin
         n_err++;
         $display("FAIL mid_frame: bitCount=%0d pOut=%h, expected 5/1f", a_cnt, a_pout);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (a_cnt !== 4'd0 || a_pout !== 8'h00 || a_done !== 1'b0) begin
         n_err++;
         $display("FAIL mid_frame_reset: bitCount=%0d pOut=%h frameDone=%b, expected 0/00/0", a_cnt, a_pout, a_done);
      end
      #2 rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++;
         if (a_done !== (i == 7) || a_cnt !== 4'((i + 1) % 8)) begin
            n_err++;
            $display("FAIL post_reset[%0d]: frameDone=%b bitCount=%0d, expected %b/%0d",
                     i, a_done, a_cnt, (i == 7), (i + 1) % 8);
         end
      end
      n_cmp++;
      if (a_pout !== 8'hFF) begin
         n_err++;
         $display("FAIL post_reset_data: pOut=%h, expected ff", a_pout);
      end
      a_sin = 1'b0;
      repeat (3) tick();
      a_en = 1'b0; a_sin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (a_pout !== 8'hF8 || a_cnt !== 4'd3 || a_done !== 1'b0) begin
            n_err++;
            $display("FAIL enable_low[%0d]: pOut=%h bitCount=%0d frameDone=%b, expected f8/3/0",
                     i, a_pout, a_cnt, a_done);
         end
      end
   endtask

   task automatic test_lsb_first();
      logic       bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_p [8] = '{8'h80, 8'h40, 8'hA0, 8'h50, 8'h28, 8'h94, 8'h4A, 8'hA5};
      b_en = 1'b1; b_mode = SHIFT;
      for (int i = 0; i < 8; i++) begin
         b_sin = bits[i];
         tick();
         n_cmp++;
         if (b_pout !== exp_p[i] || b_sout !== exp_p[i][0] || b_done !== (i == 7)) begin
            n_err++;
            $display("FAIL shift_lsb[%0d]: pOut=%h sOut=%b frameDone=%b, expected %h/%b/%b",
                     i, b_pout, b_sout, b_done, exp_p[i], exp_p[i][0], (i == 7));
         end
      end
      b_sin = 1'b0;
      repeat (7) tick();
      n_cmp++;
      if (b_cnt !== 4'd7 || b_pout !== 8'h01 || b_sout !== 1'b1) begin
         n_err++;
         $display("FAIL lsb_pre_load: bitCount=%0d pOut=%h sOut=%b, expected 7/01/1", b_cnt, b_pout, b_sout);
      end
      // Load lands on the edge that would have completed the frame.
      b_mode = LOAD; b_pin = 8'h3C;
      tick();
      n_cmp++;
      if (b_cnt !== 4'd0 || b_done !== 1'b0 || b_pout !== 8'h3C || b_sout !== 1'b0) begin
         n_err++;
         $display("FAIL load_wins: bitCount=%0d frameDone=%b pOut=%h sOut=%b, expected 0/0/3c/0",
                  b_cnt, b_done, b_pout, b_sout);
      end
      b_mode = HOLD;
      tick();
      n_cmp++;
      if (b_done !== 1'b0 || b_pout !== 8'h3C || b_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL hold_after_load: frameDone=%b pOut=%h bitCount=%0d, expected 0/3c/0", b_done, b_pout, b_cnt);
      end
   endtask

   initial begin
      rst = 1'b0;
      a_en = 1'b0; a_mode = HOLD; a_sin = 1'b0; a_pin = 8'h00;
      b_en = 1'b0; b_mode = HOLD; b_sin = 1'b0; b_pin = 8'h00;
      tick();
      tick();
      rst = 1'b1;
      test_reset();
      test_shift_msb_first();
      test_rotate();
      test_load_then_shift();
      test_reset_mid_frame();
      test_lsb_first();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
